// File: rtl/sweep_response_checker.sv
// Exhaustive self-check of a 1-output combinational circuit: steps VEC through every
// input vector, waits for the output to settle, then compares Z against TRUTH.
module sweep_response_checker #(
  parameter int                 N_IN   = 3,
  parameter logic [2**N_IN-1:0] TRUTH  = 8'hC8,
  parameter int                 SETTLE = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            z_i,
  output logic [N_IN-1:0] vec_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [N_IN:0]   err_cnt_o,
  output logic            fail_valid_o,
  output logic [N_IN-1:0] first_fail_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_MAX     = {N_IN{1'b1}};

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [N_IN:0]     err_cnt_q, err_cnt_d;
  logic              fail_valid_q, fail_valid_d;
  logic [N_IN-1:0]   first_fail_q, first_fail_d;
  logic              pass_q, pass_d;
  logic              mismatch;

  // Case equality makes an X or Z response count as a mismatch in simulation.
  assign mismatch = (z_i === TRUTH[vec_q]) ? 1'b0 : 1'b1;

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;

    case (state_q)
      ST_IDLE: begin
        vec_d = '0;
        if (start_i) begin
          state_d      = ST_SETTLE;
          cnt_d        = '0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
          pass_d       = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_cnt_d = err_cnt_q + 1'b1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            first_fail_d = vec_q;
          end
        end
        if (vec_q == VEC_MAX) begin
          state_d = ST_DONE;
          vec_d   = '0;
          // Includes the final vector's result, which is not yet in fail_valid_q.
          pass_d  = ~(mismatch | fail_valid_q);
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + 1'b1;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
    end
  end

  assign vec_o        = vec_q;
  assign busy_o       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done_o       = (state_q == ST_DONE);
  assign pass_o       = pass_q;
  assign err_cnt_o    = err_cnt_q;
  assign fail_valid_o = fail_valid_q;
  assign first_fail_o = first_fail_q;

endmodule

// File: tb/tb_sweep_response_checker.sv
// Directed bench for sweep_response_checker with a behavioural circuit that can be
// switched between the correct function, a known fault and a stuck-at-1 output.
module tb_sweep_response_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic       z;
  logic [2:0] vec;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic       fail_valid;
  logic [2:0] first_fail;

  int checks = 0;
  int errors = 0;
  int mode   = 0;  // 0: Z=AB|BC, 1: Z=AB, 2: Z stuck at 1

  sweep_response_checker #(
    .N_IN  (3),
    .TRUTH (8'hC8),
    .SETTLE(4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .z_i         (z),
    .vec_o       (vec),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .err_cnt_o   (err_cnt),
    .fail_valid_o(fail_valid),
    .first_fail_o(first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A = vec[2], B = vec[1], C = vec[0]
  always_comb begin
    case (mode)
      0:       z = (vec[2] & vec[1]) | (vec[1] & vec[0]);
      1:       z = vec[2] & vec[1];
      default: z = 1'b1;
    endcase
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives one sweep and measures it; comparisons are made by the calling test.
  task automatic sweep(input bit hold, output int busy_n, output int vec_bad, output bit done_ok);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    busy_n  = 0;
    vec_bad = 0;
    while (busy === 1'b1 && busy_n < 100) begin
      if (vec !== 3'(busy_n / 5)) vec_bad++;
      busy_n++;
      tick();
    end
    done_ok = (done === 1'b1) && (vec === 3'd0);
    $display("sweep mode=%0d busy_cycles=%0d vec_bad=%0d done=%0b pass=%0b err_cnt=%0d first_fail=%0d",
             mode, busy_n, vec_bad, done, pass, err_cnt, first_fail);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (vec !== 3'd0) begin errors++; $display("FAIL reset_vec got %0d want 0", vec); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %0b want 0", pass); end
    checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    checks++; if (fail_valid !== 1'b0) begin errors++; $display("FAIL reset_fail_valid got %0b want 0", fail_valid); end
    checks++; if (first_fail !== 3'd0) begin errors++; $display("FAIL reset_first_fail got %0d want 0", first_fail); end
    $display("reset busy=%0b vec=%0d", busy, vec);
  endtask

  task automatic test_good();
    int busy_n; int vec_bad; bit done_ok;
    mode = 0;
    sweep(1'b0, busy_n, vec_bad, done_ok);
    checks++; if (busy_n != 40) begin errors++; $display("FAIL good_busy_cycles got %0d want 40", busy_n); end
    checks++; if (vec_bad != 0) begin errors++; $display("FAIL good_vec_steps got %0d bad want 0", vec_bad); end
    checks++; if (!done_ok) begin errors++; $display("FAIL good_done got done=%0b vec=%0d want 1,0", done, vec); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL good_pass got %0b want 1", pass); end
    checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL good_err_cnt got %0d want 0", err_cnt); end
    checks++; if (fail_valid !== 1'b0) begin errors++; $display("FAIL good_fail_valid got %0b want 0", fail_valid); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL good_done_pulse got done=%0b busy=%0b want 0,0", done, busy); end
  endtask

  task automatic test_fault_ab();
    int busy_n; int vec_bad; bit done_ok;
    mode = 1;
    sweep(1'b0, busy_n, vec_bad, done_ok);
    checks++; if (!done_ok) begin errors++; $display("FAIL ab_done got done=%0b want 1", done); end
    checks++; if (err_cnt !== 4'd1) begin errors++; $display("FAIL ab_err_cnt got %0d want 1", err_cnt); end
    checks++; if (first_fail !== 3'd3) begin errors++; $display("FAIL ab_first_fail got %0d want 3", first_fail); end
    checks++; if (fail_valid !== 1'b1) begin errors++; $display("FAIL ab_fail_valid got %0b want 1", fail_valid); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL ab_pass got %0b want 0", pass); end
    tick();
  endtask

  task automatic test_stuck_then_good();
    int busy_n; int vec_bad; bit done_ok;
    mode = 2;
    sweep(1'b0, busy_n, vec_bad, done_ok);
    checks++; if (err_cnt !== 4'd5) begin errors++; $display("FAIL stuck_err_cnt got %0d want 5", err_cnt); end
    checks++; if (first_fail !== 3'd0 || fail_valid !== 1'b1) begin errors++; $display("FAIL stuck_first_fail got %0d/%0b want 0/1", first_fail, fail_valid); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL stuck_pass got %0b want 0", pass); end
    repeat (5) tick();
    checks++; if (err_cnt !== 4'd5 || fail_valid !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL stuck_hold got err=%0d fv=%0b pass=%0b want 5,1,0", err_cnt, fail_valid, pass); end
    mode = 0;
    sweep(1'b0, busy_n, vec_bad, done_ok);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL rerun_pass got %0b want 1", pass); end
    checks++; if (err_cnt !== 4'd0 || fail_valid !== 1'b0) begin errors++; $display("FAIL rerun_cleared got err=%0d fv=%0b want 0,0", err_cnt, fail_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    int busy_n; int vec_bad; bit done_ok; int k;
    mode = 2;
    start = 1'b1; tick(); start = 1'b0;
    k = 0;
    while (vec !== 3'd4 && k < 100) begin k++; tick(); end
    checks++; if (vec !== 3'd4 || busy !== 1'b1) begin errors++; $display("FAIL mid_reach_vec4 got vec=%0d busy=%0b want 4,1", vec, busy); end
    checks++; if (err_cnt !== 4'd3) begin errors++; $display("FAIL mid_partial_err got %0d want 3", err_cnt); end
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (vec !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl got vec=%0d busy=%0b done=%0b want 0,0,0", vec, busy, done); end
    checks++; if (err_cnt !== 4'd0 || fail_valid !== 1'b0 || first_fail !== 3'd0 || pass !== 1'b0) begin errors++; $display("FAIL mid_rst_results got err=%0d fv=%0b ff=%0d pass=%0b want 0", err_cnt, fail_valid, first_fail, pass); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle got busy=%0b want 0", busy); end
    mode = 0;
    sweep(1'b0, busy_n, vec_bad, done_ok);
    checks++; if (busy_n != 40 || !done_ok) begin errors++; $display("FAIL mid_resweep got busy=%0d done=%0b want 40,1", busy_n, done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL mid_resweep_pass got %0b want 1", pass); end
    tick();
  endtask

  task automatic test_back_to_back();
    int busy_n; int vec_bad; bit done_ok; int n;
    mode = 0;
    sweep(1'b1, busy_n, vec_bad, done_ok);
    checks++; if (busy_n != 40 || !done_ok) begin errors++; $display("FAIL b2b_first got busy=%0d done=%0b want 40,1", busy_n, done); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%0b done=%0b want 0,0", busy, done); end
    tick();
    checks++; if (busy !== 1'b1 || vec !== 3'd0 || err_cnt !== 4'd0 || pass !== 1'b0) begin errors++; $display("FAIL b2b_rearm got busy=%0b vec=%0d err=%0d pass=%0b want 1,0,0,0", busy, vec, err_cnt, pass); end
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; tick(); end
    start = 1'b0;
    checks++; if (n != 40 || done !== 1'b1) begin errors++; $display("FAIL b2b_second got busy=%0d done=%0b want 40,1", n, done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL b2b_pass got %0b want 1", pass); end
    $display("back_to_back second_busy=%0d pass=%0b", n, pass);
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_good();
    test_fault_ab();
    test_stuck_then_good();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
